// File: rtl/bus_pkg.sv
// Shared types and constants for the bus address arbiter.
package bus_pkg;
   localparam int CNT_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending channel after last_grant.
module rr_pick
   import bus_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]         pending,
   input  logic [$clog2(NCH)-1:0] last_grant,
   output logic [$clog2(NCH)-1:0] grant,
   output logic                   any
);
   localparam int SW = $clog2(NCH);

   function automatic logic [SW-1:0] wrap(input int base, input int off);
      return SW'((base + off) % NCH);
   endfunction

   // rot[0] is the channel just after last_grant, i.e. highest priority.
   logic [NCH-1:0] rot;
   for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
      assign rot[gi] = pending[wrap(int'(last_grant), 1 + gi)];
   end

   always_comb begin
      grant = last_grant;
      for (int j = NCH - 1; j >= 0; j--) begin
         if (rot[j]) grant = wrap(int'(last_grant), 1 + j);
      end
   end

   assign any = |pending;
endmodule

// File: rtl/bus_addr_arb.sv
// Round-robin arbiter steering a shared mux bus: after each grant it waits
// DELAY settle cycles, then captures a one- or two-word address and acks.
module bus_addr_arb
   import bus_pkg::*;
#(
   parameter int             NCH      = 4,
   parameter int             DW       = 16,
   parameter int             DELAY    = 1,
   parameter logic [NCH-1:0] TWO_WORD = {{(NCH-1){1'b0}}, 1'b1}
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH-1:0]         req,
   input  logic [DW-1:0]          bus,
   output logic                   sel_vld,
   output logic [$clog2(NCH)-1:0] sel_ch,
   output logic                   sel_wd,
   output logic [2*DW-1:0]        addr,
   output logic [NCH-1:0]         ack
);
   localparam int              SW      = $clog2(NCH);
   localparam logic [CNT_W-1:0] DLY_CNT = CNT_W'(DELAY);

   state_t           state;
   logic [NCH-1:0]   pending;
   logic [NCH-1:0]   take;
   logic [SW-1:0]    last_grant;
   logic [SW-1:0]    grant;
   logic [CNT_W-1:0] cnt;
   logic             wd;
   logic             any;

   rr_pick #(.NCH(NCH)) u_pick (
      .pending    (pending),
      .last_grant (last_grant),
      .grant      (grant),
      .any        (any)
   );

   always_comb begin
      take = '0;
      if (state == IDLE && any) take[grant] = 1'b1;
   end

   assign sel_wd = wd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         cnt        <= '0;
         wd         <= 1'b0;
         sel_vld    <= 1'b0;
         sel_ch     <= '0;
         addr       <= '0;
         ack        <= '0;
         last_grant <= SW'(NCH - 1);
      end else begin
         ack <= '0;
         // A new request on the granting edge survives the clear.
         pending <= (pending & ~take) | req;
         case (state)
            IDLE: begin
               wd <= 1'b0;
               if (any) begin
                  sel_vld    <= 1'b1;
                  sel_ch     <= grant;
                  last_grant <= grant;
                  cnt        <= DLY_CNT;
                  state      <= WAIT;
               end else begin
                  sel_vld <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!wd) begin
                  addr[DW-1:0] <= bus;
                  if (TWO_WORD[sel_ch]) begin
                     wd  <= 1'b1;
                     cnt <= DLY_CNT;
                  end else begin
                     addr[2*DW-1:DW] <= '0;
                     ack[sel_ch]     <= 1'b1;
                     state           <= IDLE;
                  end
               end else begin
                  addr[2*DW-1:DW] <= bus;
                  ack[sel_ch]     <= 1'b1;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
